pe_acc_drain: RTL and testbench

- Parametrised systolic-array processing element, successor to the 8-bit fixed-width MAC PE.
- Forwards activation (east) and weight (south) by one register stage per fire.
- Two-stage multiply-accumulate with signed/unsigned mode, explicit accumulation restart and optional saturation.
- Adds a per-column drain shift chain, so results stream out of the array without a wide parallel readout bus.

---
 rtl/pe_acc_drain.sv | 124 ++++++++++++
 tb/tb_pe_acc_drain.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/pe_acc_drain.sv
// rtl/pe_acc_drain.sv - systolic PE: operand forwarding, two-stage MAC with restart/saturation, drain shift chain
module pe_acc_drain #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24,
  parameter int SIGNED = 0,
  parameter int SAT    = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              fire,
  input  logic              first,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_w,
  output logic              out_f,
  output logic              out_first,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_w,
  input  logic              drain,
  input  logic [ACC_W-1:0]  drain_in,
  input  logic              drain_in_v,
  output logic [ACC_W-1:0]  drain_out,
  output logic              drain_out_v,
  output logic              sat_flag
);

  localparam int PW = 2 * DATA_W;
  localparam int XW = ACC_W + 1;

  generate
    if (ACC_W < 2 * DATA_W) begin : g_bad_acc_w
      $error("pe_acc_drain: ACC_W must be >= 2*DATA_W");
    end
  endgenerate

  logic [PW-1:0]    opa, opw, mul, prod;
  logic             prod_v, prod_first, drain_q;
  logic [ACC_W-1:0] acc, acc_nxt;
  logic             sat_nxt;
  logic [XW-1:0]    ext, acc_x, sum;

  // Operands widened to the product width so a plain multiply gives the
  // correct low 2*DATA_W bits for both signed and unsigned modes.
  always_comb begin
    if (SIGNED != 0) begin
      opa   = {{DATA_W{in_a[DATA_W-1]}}, in_a};
      opw   = {{DATA_W{in_w[DATA_W-1]}}, in_w};
      ext   = {{(XW-PW){prod[PW-1]}}, prod};
      acc_x = {acc[ACC_W-1], acc};
    end else begin
      opa   = {{DATA_W{1'b0}}, in_a};
      opw   = {{DATA_W{1'b0}}, in_w};
      ext   = {{(XW-PW){1'b0}}, prod};
      acc_x = {1'b0, acc};
    end
    mul = opa * opw;
    sum = acc_x + ext;
  end

  always_comb begin
    acc_nxt = acc;
    sat_nxt = sat_flag;
    if (prod_first) begin
      acc_nxt = ext[ACC_W-1:0];
      sat_nxt = 1'b0;
    end else begin
      acc_nxt = sum[ACC_W-1:0];
      if (SAT != 0) begin
        // Signed overflow shows as disagreement between the guard bit and the MSB.
        if (SIGNED != 0) begin
          if (sum[ACC_W] != sum[ACC_W-1]) begin
            acc_nxt = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
            sat_nxt = 1'b1;
          end
        end else if (sum[ACC_W]) begin
          acc_nxt = '1;
          sat_nxt = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      out_f       <= 1'b0;
      out_first   <= 1'b0;
      out_a       <= '0;
      out_w       <= '0;
      prod        <= '0;
      prod_v      <= 1'b0;
      prod_first  <= 1'b0;
      acc         <= '0;
      sat_flag    <= 1'b0;
      drain_q     <= 1'b0;
      drain_out   <= '0;
      drain_out_v <= 1'b0;
    end else begin
      out_f     <= fire;
      out_first <= fire & first;
      prod_v    <= fire;
      if (fire) begin
        out_a      <= in_a;
        out_w      <= in_w;
        prod       <= mul;
        prod_first <= first;
      end
      if (prod_v) begin
        acc      <= acc_nxt;
        sat_flag <= sat_nxt;
      end
      drain_q <= drain;
      // Capture samples acc before this edge's stage-2 update.
      if (drain && !drain_q) begin
        drain_out   <= acc;
        drain_out_v <= 1'b1;
      end else if (drain) begin
        drain_out   <= drain_in;
        drain_out_v <= drain_in_v;
      end else begin
        drain_out_v <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pe_acc_drain.sv
// tb/tb_pe_acc_drain.sv - four single PEs of different configs against an arithmetic model, plus a 4-deep drain column
module tb_pe_acc_drain;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn = 1'b0;
  logic        fire = 1'b0, first = 1'b0, drain = 1'b0, div = 1'b0;
  logic [7:0]  in_a = '0, in_w = '0;
  logic [23:0] din = '0;

  logic        s_of[4], s_ofirst[4], s_dv[4], s_sat[4];
  logic [7:0]  s_oa[4], s_ow[4];
  logic [23:0] s_dout[4];

  int  c_aw[4] = '{24, 16, 16, 16};
  bit  c_sg[4] = '{0, 0, 1, 1};
  bit  c_st[4] = '{1, 1, 1, 0};

  genvar g;
  for (g = 0; g < 4; g++) begin : g_pe
    localparam int AW = (g == 0) ? 24 : 16;
    logic [AW-1:0] dq;
    pe_acc_drain #(.DATA_W(8), .ACC_W(AW), .SIGNED((g >= 2) ? 1 : 0), .SAT((g == 3) ? 0 : 1)) u_dut (
      .clk(clk), .rstn(rstn), .fire(fire), .first(first), .in_a(in_a), .in_w(in_w),
      .out_f(s_of[g]), .out_first(s_ofirst[g]), .out_a(s_oa[g]), .out_w(s_ow[g]),
      .drain(drain), .drain_in(din[AW-1:0]), .drain_in_v(div),
      .drain_out(dq), .drain_out_v(s_dv[g]), .sat_flag(s_sat[g]));
    assign s_dout[g] = 24'(dq);
  end

  logic        c_fire = 1'b0, c_first = 1'b0, c_drain = 1'b0;
  logic [7:0]  c_a[4], c_w = '0;
  logic        c_of[4], c_ofirst[4], c_dv[4], c_sat[4];
  logic [7:0]  c_oa[4], c_ow[4];
  logic [23:0] c_dout[4];
  initial for (int i = 0; i < 4; i++) c_a[i] = '0;

  for (g = 0; g < 4; g++) begin : g_col
    logic [23:0] up_d;
    logic        up_v;
    if (g == 0) begin : g_top
      assign up_d = '0;
      assign up_v = 1'b0;
    end else begin : g_mid
      assign up_d = c_dout[g-1];
      assign up_v = c_dv[g-1];
    end
    pe_acc_drain u_pe (
      .clk(clk), .rstn(rstn), .fire(c_fire), .first(c_first), .in_a(c_a[g]), .in_w(c_w),
      .out_f(c_of[g]), .out_first(c_ofirst[g]), .out_a(c_oa[g]), .out_w(c_ow[g]),
      .drain(c_drain), .drain_in(up_d), .drain_in_v(up_v),
      .drain_out(c_dout[g]), .drain_out_v(c_dv[g]), .sat_flag(c_sat[g]));
  end

  int     vectors = 0, miscompares = 0;
  longint m_acc[4];
  bit     m_flag[4];

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: each fired product is folded into an integer accumulator using
  // the documented clamp/wrap rules; the pipeline delay is hidden by reading late.
  function automatic void mstep(int k, logic [7:0] a, logic [7:0] w, bit fst);
    longint p, s, mx, mn, span;
    span = longint'(1) << c_aw[k];
    if (c_sg[k]) begin
      p  = longint'($signed(a)) * longint'($signed(w));
      mx = span / 2 - 1;
      mn = -(span / 2);
    end else begin
      p  = longint'(a) * longint'(w);
      mx = span - 1;
      mn = 0;
    end
    if (fst) begin
      m_acc[k]  = p;
      m_flag[k] = 1'b0;
    end else begin
      s = m_acc[k] + p;
      if (c_st[k]) begin
        if (s > mx) begin s = mx; m_flag[k] = 1'b1; end
        else if (s < mn) begin s = mn; m_flag[k] = 1'b1; end
      end else begin
        s = s & (span - 1);
        if (s > mx) s = s - span;
      end
      m_acc[k] = s;
    end
  endfunction

  task automatic step(bit f, bit fi, logic [7:0] a, logic [7:0] w, bit d);
    fire = f; first = fi; in_a = a; in_w = w; drain = d;
    if (f && rstn) for (int k = 0; k < 4; k++) mstep(k, a, w, fi);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_fwd(string tag, logic [7:0] a, logic [7:0] w, bit fi);
    chk({tag, "/out_a"}, 64'(s_oa[0]), 64'(a));
    chk({tag, "/out_w"}, 64'(s_ow[0]), 64'(w));
    chk({tag, "/out_f"}, 64'(s_of[0]), 64'd1);
    chk({tag, "/out_first"}, 64'(s_ofirst[0]), 64'(fi));
  endtask

  task automatic read_acc(string tag);
    logic [63:0] exp;
    step(0, 0, 8'h00, 8'h00, 0);
    step(0, 0, 8'h00, 8'h00, 1);
    for (int k = 0; k < 4; k++) begin
      exp = 64'(m_acc[k]) & ((64'd1 << c_aw[k]) - 64'd1);
      chk($sformatf("%s/pe%0d/v", tag, k), 64'(s_dv[k]), 64'd1);
      chk($sformatf("%s/pe%0d/acc", tag, k), 64'(s_dout[k]), exp);
      chk($sformatf("%s/pe%0d/sat", tag, k), 64'(s_sat[k]), 64'(m_flag[k]));
    end
    step(0, 0, 8'h00, 8'h00, 0);
    for (int k = 0; k < 4; k++)
      chk($sformatf("%s/pe%0d/v_idle", tag, k), 64'(s_dv[k]), 64'd0);
  endtask

  function automatic logic [7:0] pick();
    case ($urandom_range(0, 4))
      0: return 8'hFF;
      1: return 8'h80;
      2: return 8'h7F;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    logic [7:0] a, w;
    bit fi;
    int n;
    for (int k = 0; k < 4; k++) begin m_acc[k] = 0; m_flag[k] = 1'b0; end

    rstn = 1'b0; din = 24'hABCDEF; div = 1'b1;
    c_fire = 1'b1; c_first = 1'b1; c_drain = 1'b1; c_w = 8'h33;
    step(1, 1, 8'h5A, 8'hA5, 1);
    step(1, 1, 8'h5A, 8'hA5, 1);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rst/pe%0d/out_f", k), 64'(s_of[k]), 0);
      chk($sformatf("rst/pe%0d/out_first", k), 64'(s_ofirst[k]), 0);
      chk($sformatf("rst/pe%0d/out_a", k), 64'(s_oa[k]), 0);
      chk($sformatf("rst/pe%0d/out_w", k), 64'(s_ow[k]), 0);
      chk($sformatf("rst/pe%0d/dout", k), 64'(s_dout[k]), 0);
      chk($sformatf("rst/pe%0d/dv", k), 64'(s_dv[k]), 0);
      chk($sformatf("rst/pe%0d/sat", k), 64'(s_sat[k]), 0);
    end
    rstn = 1'b1; din = '0; div = 1'b0;
    c_fire = 1'b0; c_first = 1'b0; c_drain = 1'b0;
    step(0, 0, 8'h00, 8'h00, 0);
    step(0, 0, 8'h00, 8'h00, 0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("post_rst/pe%0d/out_f", k), 64'(s_of[k]), 0);
      chk($sformatf("post_rst/pe%0d/out_a", k), 64'(s_oa[k]), 0);
      chk($sformatf("post_rst/pe%0d/dv", k), 64'(s_dv[k]), 0);
      chk($sformatf("post_rst/pe%0d/sat", k), 64'(s_sat[k]), 0);
    end

    step(1, 1, 8'd3, 8'd4, 0);     chk_fwd("mac1", 8'd3, 8'd4, 1);
    step(1, 0, 8'd5, 8'd6, 0);     chk_fwd("mac2", 8'd5, 8'd6, 0);
    step(1, 0, 8'd255, 8'd255, 0); chk_fwd("mac3", 8'd255, 8'd255, 0);
    step(0, 1, 8'd9, 8'd9, 0);
    chk("hold/out_a", 64'(s_oa[0]), 64'd255);
    chk("hold/out_f", 64'(s_of[0]), 64'd0);
    chk("hold/out_first", 64'(s_ofirst[0]), 64'd0);
    chk("mac/def_acc_const", 64'(m_acc[0]), 64'd65067);
    read_acc("mac");

    step(1, 1, 8'd255, 8'd255, 0);
    step(1, 0, 8'd255, 8'd255, 0);
    read_acc("usat");
    step(1, 1, 8'd2, 8'd2, 0);
    read_acc("restart");

    step(1, 1, 8'h80, 8'h7F, 0);
    step(1, 0, 8'h80, 8'h7F, 0);
    step(1, 0, 8'h80, 8'h7F, 0);
    read_acc("ssat");

    for (int grp = 0; grp < 25; grp++) begin
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        a = pick(); w = pick();
        fi = (i == 0) || ($urandom_range(0, 7) == 0);
        if (i != 0 && $urandom_range(0, 3) == 0) step(0, 1, a, w, 0);
        step(1, fi, a, w, 0);
        chk_fwd($sformatf("rnd%0d.%0d", grp, i), a, w, fi);
      end
      read_acc($sformatf("rnd%0d", grp));
    end

    for (int k = 0; k < 4; k++) c_a[k] = 8'(10 * (k + 1));
    c_w = 8'd1; c_fire = 1'b1; c_first = 1'b1;
    @(posedge clk); #1;
    c_fire = 1'b0; c_first = 1'b0;
    @(posedge clk); #1;
    c_drain = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      c_fire = 1'b1;
      for (int k = 0; k < 4; k++) c_a[k] = 8'($urandom);
      c_w = 8'($urandom);
      if (i < 4) begin
        chk($sformatf("chain%0d/v", i), 64'(c_dv[3]), 64'd1);
        chk($sformatf("chain%0d/d", i), 64'(c_dout[3]), 64'(40 - 10 * i));
      end else begin
        chk("chain_end/v", 64'(c_dv[3]), 64'd0);
      end
    end
    c_drain = 1'b0; c_fire = 1'b0;

    step(1, 1, 8'd9, 8'd9, 0);
    step(1, 0, 8'd9, 8'd9, 1);
    rstn = 1'b0;
    step(0, 0, 8'h00, 8'h00, 0);
    rstn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      m_acc[k] = 0; m_flag[k] = 1'b0;
      chk($sformatf("midrst/pe%0d/dv", k), 64'(s_dv[k]), 0);
      chk($sformatf("midrst/pe%0d/dout", k), 64'(s_dout[k]), 0);
      chk($sformatf("midrst/pe%0d/out_f", k), 64'(s_of[k]), 0);
    end
    step(1, 1, 8'd7, 8'd7, 0);
    chk("midrst/const49", 64'(m_acc[0]), 64'd49);
    read_acc("midrst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
